// File: rtl/baud_tick_gen_if.sv
// Control/status bundle for the baud-rate tick generator.
// master drives enable, resync and divisor loads; slave is the generator.
interface baud_tick_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);
  logic              en;
  logic              resync;
  logic              cfg_wr;
  logic [DIV_W-1:0]  div_int_in;
  logic [FRAC_W-1:0] div_frac_in;
  logic              cfg_pending;
  logic              os_tick;
  logic              bit_tick;
  logic              mid_tick;
  logic              baud_clk;

  modport master (
    output en, resync, cfg_wr, div_int_in, div_frac_in,
    input  cfg_pending, os_tick, bit_tick, mid_tick, baud_clk
  );

  modport slave (
    input  en, resync, cfg_wr, div_int_in, div_frac_in,
    output cfg_pending, os_tick, bit_tick, mid_tick, baud_clk
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Fractional baud-rate timing generator.
// A period counter produces oversample ticks every div_int (+1 when the
// fractional accumulator carries) clocks; an oversample counter derives the
// bit tick, the mid-bit sample tick and a square-wave baud_clk from them.
// Every output is a flop, so no input reaches an output combinationally.
module baud_tick_gen #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int DEF_INT    = 651,
  parameter int DEF_FRAC   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  baud_tick_gen_if.slave bus
);

  localparam int OSW = $clog2(OVERSAMPLE);

  // Divisors below 2 would make the period counter degenerate.
  localparam logic [DIV_W-1:0]  MIN_DIV    = DIV_W'(2);
  localparam logic [DIV_W-1:0]  DEF_INT_C  = (DEF_INT < 2) ? MIN_DIV : DIV_W'(DEF_INT);
  localparam logic [FRAC_W-1:0] DEF_FRAC_C = FRAC_W'(DEF_FRAC);
  localparam logic [OSW-1:0]    OS_LAST    = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0]    OS_MID     = OSW'(OVERSAMPLE / 2 - 1);

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

  // active and shadow divisors
  logic [DIV_W-1:0]  div_int_q, sh_int;
  logic [FRAC_W-1:0] div_frac_q, sh_frac;
  logic              pend;

  // period / phase state
  logic [DIV_W:0]    cnt;      // P may reach 2^DIV_W, so one extra bit
  logic [FRAC_W-1:0] acc;
  logic              ext;      // current period lengthened by one clk
  logic [OSW-1:0]    os_cnt;

  // registered outputs
  logic              os_q, bit_q, mid_q, bclk_q;

  logic [DIV_W:0]    per_m1;
  logic [FRAC_W:0]   acc_sum;
  logic              at_end;
  logic              bnd;
  logic              apply_sh;

  assign per_m1  = {1'b0, div_int_q} + {{DIV_W{1'b0}}, ext} - {{DIV_W{1'b0}}, 1'b1};
  assign acc_sum = {1'b0, acc} + {1'b0, div_frac_q};
  assign at_end  = (cnt == per_m1);
  // A boundary only counts while running; resync suppresses it.
  assign bnd     = bus.en && !bus.resync && at_end;
  // Pending shadow takes effect at a boundary, or straight away when frozen.
  assign apply_sh = pend && (bnd || !bus.en);

  // Divisor shadow capture and hand-over to the active divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_int_q  <= DEF_INT_C;
      div_frac_q <= DEF_FRAC_C;
      sh_int     <= DEF_INT_C;
      sh_frac    <= DEF_FRAC_C;
      pend       <= 1'b0;
    end else if (bus.resync) begin
      // resync consumes any load: a simultaneous write wins over the shadow
      if (bus.cfg_wr) begin
        div_int_q  <= clamp_div(bus.div_int_in);
        div_frac_q <= bus.div_frac_in;
        sh_int     <= clamp_div(bus.div_int_in);
        sh_frac    <= bus.div_frac_in;
      end else if (pend) begin
        div_int_q  <= sh_int;
        div_frac_q <= sh_frac;
      end
      pend <= 1'b0;
    end else begin
      if (apply_sh) begin
        div_int_q  <= sh_int;
        div_frac_q <= sh_frac;
      end
      // a write in the same cycle as a hand-over stays pending for the next
      if (bus.cfg_wr) begin
        sh_int  <= clamp_div(bus.div_int_in);
        sh_frac <= bus.div_frac_in;
        pend    <= 1'b1;
      end else if (apply_sh) begin
        pend <= 1'b0;
      end
    end
  end

  // Period counter, fractional accumulator and oversample phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      ext    <= 1'b0;
      os_cnt <= '0;
    end else if (bus.resync) begin
      cnt    <= '0;
      acc    <= '0;
      ext    <= 1'b0;
      os_cnt <= '0;
    end else if (bus.en) begin
      if (at_end) begin
        cnt        <= '0;
        {ext, acc} <= acc_sum;
        os_cnt     <= (os_cnt == OS_LAST) ? '0 : os_cnt + {{(OSW-1){1'b0}}, 1'b1};
      end else begin
        cnt <= cnt + {{DIV_W{1'b0}}, 1'b1};
      end
    end
  end

  // Tick pulses one cycle after the boundary; baud_clk flips with bit_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_q   <= 1'b0;
      bit_q  <= 1'b0;
      mid_q  <= 1'b0;
      bclk_q <= 1'b0;
    end else begin
      os_q  <= bnd;
      bit_q <= bnd && (os_cnt == OS_LAST);
      mid_q <= bnd && (os_cnt == OS_MID);
      if (bnd && (os_cnt == OS_LAST))
        bclk_q <= ~bclk_q;
    end
  end

  assign bus.os_tick     = os_q;
  assign bus.bit_tick    = bit_q;
  assign bus.mid_tick    = mid_q;
  assign bus.baud_clk    = bclk_q;
  assign bus.cfg_pending = pend;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: OVERSAMPLE=4, DEF_INT=4, DEF_FRAC=0.
module tb_baud_tick_gen;
  localparam int OS = 4;
  localparam int DW = 8;
  localparam int FW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  baud_tick_gen_if #(.DIV_W(DW), .FRAC_W(FW)) bus ();

  baud_tick_gen #(
    .OVERSAMPLE(OS), .DIV_W(DW), .FRAC_W(FW), .DEF_INT(4), .DEF_FRAC(0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int qat(input int q[$], input int k);
    if (k < q.size()) return q[k];
    return -1;
  endfunction

  // per-edge trace: first 64 edges as bit vectors, all tick positions as lists
  logic [63:0] v_os, v_bit, v_mid, v_bclk;
  int osq[$], bitq[$], midq[$];

  task automatic trace(input int n);
    v_os = '0; v_bit = '0; v_mid = '0; v_bclk = '0;
    osq.delete(); bitq.delete(); midq.delete();
    for (int i = 1; i <= n; i++) begin
      adv();
      if (i <= 64) begin
        v_os[i-1]   = bus.os_tick;
        v_bit[i-1]  = bus.bit_tick;
        v_mid[i-1]  = bus.mid_tick;
        v_bclk[i-1] = bus.baud_clk;
      end
      if (bus.os_tick)  osq.push_back(i);
      if (bus.bit_tick) bitq.push_back(i);
      if (bus.mid_tick) midq.push_back(i);
    end
  endtask

  // load a divisor together with a resync: active right after the clear
  task automatic load_resync(input int di, input int df);
    bus.cfg_wr      = 1'b1;
    bus.resync      = 1'b1;
    bus.div_int_in  = DW'(di);
    bus.div_frac_in = FW'(df);
    adv();
    bus.cfg_wr = 1'b0;
    bus.resync = 1'b0;
  endtask

  // expected pattern for divisor 4, oversample 4, starting from a clean phase
  logic [63:0] e_os, e_bit, e_mid, e_bclk;
  logic        bc0;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 1; i <= 64; i++) begin
      e_os[i-1]   = (i % 4 == 0);
      e_bit[i-1]  = (i % 16 == 0);
      e_mid[i-1]  = (i % 16 == 8);
      e_bclk[i-1] = ((i / 16) % 2 == 1);
    end
    rst_n = 1'b0;
    bus.en = 1'b0; bus.resync = 1'b0; bus.cfg_wr = 1'b0;
    bus.div_int_in = '0; bus.div_frac_in = '0;
    adv(); adv();
    chk("rst_outs", {bus.os_tick, bus.bit_tick, bus.mid_tick, bus.baud_clk, bus.cfg_pending}, 0);

    // 1: default divisor, free run
    rst_n = 1'b1; bus.en = 1'b1;
    trace(64);
    chk("t1_os", v_os, e_os);
    chk("t1_bit", v_bit, e_bit);
    chk("t1_mid", v_mid, e_mid);
    chk("t1_bclk", v_bclk, e_bclk);

    // 2: fractional 4 + 1/4 -> every 4th period from the 5th is 5 clks
    load_resync(4, 1);
    chk("t2_pend", bus.cfg_pending, 0);
    trace(300);
    chk("t2_first_os", qat(osq, 0), 4);
    chk("t2_os5", qat(osq, 4), 21);
    chk("t2_os9", qat(osq, 8), 38);
    chk("t2_span64", qat(osq, 64) - qat(osq, 0), 272);

    // 3: resync at cnt=2, os_cnt=3 restarts the bit phase
    load_resync(4, 0);
    for (int i = 0; i < 14; i++) adv();
    bc0 = bus.baud_clk;
    bus.resync = 1'b1;
    adv();
    bus.resync = 1'b0;
    chk("t3_rs_bclk", bus.baud_clk, bc0);
    trace(64);
    chk("t3_os", v_os, e_os);
    chk("t3_bit", v_bit, e_bit);
    chk("t3_mid", v_mid, e_mid);
    chk("t3_bclk", v_bclk, e_bclk ^ {64{bc0}});

    // 3b: resync in a boundary cycle swallows that tick
    load_resync(4, 0);
    for (int i = 0; i < 3; i++) adv();
    bus.resync = 1'b1;
    adv();
    bus.resync = 1'b0;
    chk("t3b_no_tick", bus.os_tick, 0);
    trace(8);
    chk("t3b_next_os", qat(osq, 0), 4);

    // 4: mid-period load of 6 applies from the following period
    load_resync(4, 0);
    adv(); adv();
    bus.cfg_wr = 1'b1; bus.div_int_in = DW'(6);
    adv();
    bus.cfg_wr = 1'b0;
    chk("t4_pend_set", bus.cfg_pending, 1);
    adv();
    chk("t4_cur_per", bus.os_tick, 1);
    chk("t4_pend_clr", bus.cfg_pending, 0);
    trace(12);
    chk("t4_next_os", qat(osq, 0), 6);
    chk("t4_next_os2", qat(osq, 1), 12);
    load_resync(0, 0);
    trace(8);
    chk("t4_clamp", v_os[7:0], 64'hAA);

    // 5: freeze mid-period for 10 clks
    load_resync(4, 0);
    adv(); adv();
    bc0 = bus.baud_clk;
    bus.en = 1'b0;
    trace(10);
    chk("t5_gap_ticks", osq.size() + bitq.size() + midq.size(), 0);
    chk("t5_gap_bclk", bus.baud_clk, bc0);
    bus.en = 1'b1;
    trace(8);
    chk("t5_resume_os", qat(osq, 0), 2);
    chk("t5_resume_os2", qat(osq, 1), 6);
    // load while frozen applies on the next cycle; held cnt=2 ends a 3-period
    bus.en = 1'b0;
    bus.cfg_wr = 1'b1; bus.div_int_in = DW'(3);
    adv();
    bus.cfg_wr = 1'b0;
    chk("t5_frz_pend", bus.cfg_pending, 1);
    adv();
    chk("t5_frz_apply", bus.cfg_pending, 0);
    bus.en = 1'b1;
    trace(8);
    chk("t5_p3_os", qat(osq, 0), 1);
    chk("t5_p3_os2", qat(osq, 1), 4);

    // 6: async reset with baud_clk high and a load pending
    load_resync(4, 0);
    for (int i = 0; i < 40; i++) begin
      if (bus.baud_clk) break;
      adv();
    end
    chk("t6_pre_bclk", bus.baud_clk, 1);
    adv(); adv();
    bus.cfg_wr = 1'b1; bus.div_int_in = DW'(6);
    adv();
    bus.cfg_wr = 1'b0;
    chk("t6_pre_pend", bus.cfg_pending, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_outs", {bus.os_tick, bus.bit_tick, bus.mid_tick, bus.baud_clk, bus.cfg_pending}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    trace(64);
    chk("t6_os", v_os, e_os);
    chk("t6_bit", v_bit, e_bit);
    chk("t6_mid", v_mid, e_mid);
    chk("t6_bclk", v_bclk, e_bclk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
Parametrised baud-rate timing generator for the UART path that streams TRNG output. It produces a single-cycle oversample tick, a bit tick and a mid-bit sample tick. It also keeps a square-wave baud_clk output so existing consumers continue to work. The divisor is fractional and reprogrammable at run time, and a resync input realigns the phase for RX start-bit detection.

Parameters:
OVERSAMPLE, 16, oversample ticks per bit; even, 4..64
DIV_W, 16, width of the integer divisor
FRAC_W, 4, width of the fractional divisor (units of 1/2^FRAC_W clock)
DEF_INT, 651, integer divisor after reset (100 MHz / (9600*16) = 651.04)
DEF_FRAC, 1, fractional divisor after reset

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; low freezes all counters
resync  in  1  one-cycle pulse; restarts the bit phase
cfg_wr  in  1  one-cycle pulse; request to load div_int_in/div_frac_in
div_int_in  in  DIV_W  new integer divisor
div_frac_in  in  FRAC_W  new fractional divisor
cfg_pending  out  1  a loaded divisor is waiting to be applied
os_tick  out  1  oversample pulse, one clk wide
bit_tick  out  1  bit-period pulse, one clk wide
mid_tick  out  1  mid-bit sample pulse, one clk wide
baud_clk  out  1  toggles on every bit_tick

Behaviour:
- Reset (async assert, sync release): cnt=0, acc=0, os_cnt=0, ext=0. All tick outputs 0, baud_clk=0, cfg_pending=0. Active divisor = DEF_INT/DEF_FRAC.
- Active divisor: div_int_q, div_frac_q. Any div_int value below 2 is clamped to 2, both at load and for DEF_INT.
- Period counter cnt: counts 0..P-1, where P = div_int_q + ext. Counting happens only while en=1. The cycle with cnt==P-1 is the boundary.
- All outputs are registered. os_tick is high in the cycle after the boundary cycle.
- Net effect: the first os_tick arrives exactly div_int_q clk edges after the edge that samples en=1 (or ends resync/reset). After that, os_ticks are spaced by P.
- Fraction: at each boundary, {carry, acc} <= acc + div_frac_q. ext <= carry, so the next period is lengthened by one clk.
- Over every 2^FRAC_W consecutive periods, exactly div_frac_q of them are lengthened.
- os_cnt: increments modulo OVERSAMPLE at each boundary.
- bit_tick fires together with the os_tick produced when os_cnt goes OVERSAMPLE-1 -> 0.
- mid_tick fires together with the os_tick produced when os_cnt goes OVERSAMPLE/2-1 -> OVERSAMPLE/2.
- baud_clk toggles in the same cycle that bit_tick is high.
- en=0: cnt, acc, ext, os_cnt and baud_clk hold their values; tick outputs are 0. When en rises, counting resumes from the held cnt.
- resync=1: the next cycle clears cnt, acc, ext and os_cnt. No tick is output for the resync cycle, and baud_clk is unchanged.
  - Result: the first mid_tick comes (OVERSAMPLE/2)*div_int edges later (with frac=0).
  - resync overrides a boundary occurring in the same cycle; that tick is suppressed.
- cfg_wr: captures div_int_in/div_frac_in into a shadow register and sets cfg_pending the next cycle.
  - The shadow value becomes active at the next boundary (it governs the following period), or on a resync. cfg_pending clears in that same cycle.
  - If en=0, it is applied on the cycle after capture.
  - A second cfg_wr while pending overwrites the shadow (last write wins).
  - cfg_wr and resync in the same cycle: the new divisor is active immediately after the resync clear.
- Widths: the acc adder is FRAC_W+1 bits. P can reach 2^DIV_W, so cnt is DIV_W+1 bits. No other overflow is possible.
- No combinational path from any input to any output.

Test Plan:
1. Reset with OVERSAMPLE=4, DEF_INT=4, DEF_FRAC=0, then hold en=1 -> os_tick every 4 clks (first on the 4th edge); bit_tick every 16 clks; mid_tick 8 clks after each bit_tick; baud_clk period 32 clks.
2. DEF_INT=4, FRAC_W=2, DEF_FRAC=1, run 64 os periods -> period lengths repeat the pattern 4,4,4,5 (shifted by one per ext rule); total of exactly 272 clks per 64 os_ticks.
3. Pulse resync at cnt=2 while os_cnt=3 -> no bit_tick at the old boundary; next os_tick 4 clks after the resync cycle; mid_tick 8 clks after resync; baud_clk unchanged.
4. Pulse cfg_wr with div_int_in=6 mid-period -> cfg_pending=1 until the boundary; the current period remains 4, the next and later periods are 6. Also load div_int_in=0 -> period is 2.
5. Drop en for 10 clks mid-period, then restore -> no ticks during the gap; the remaining count completes (periods before and after sum to 4 active clks); baud_clk is held.
6. Assert rst_n=0 asynchronously mid-bit with a pending cfg -> all outputs 0 with no clk edge; cfg_pending=0; after release the divisor is back at DEF_INT (timing as in scenario 1).
